mem_access_ctrl: RTL and testbench

- Sequences every memory transaction of the multi-cycle CPU: instruction fetch, word load and word store.
- Sits between the CPU control/datapath and the unified instruction/data memory. The memory has a combinational read and a write on the clk edge.
- Accepts one request at a time over a valid/ready handshake and drives the memory's address, write-data, read-enable and write-enable lines.
- Latches fetched words into the instruction register and loaded words into the memory-data register, then returns a one-cycle response. Misaligned, out-of-range and instruction-region-store requests are rejected with an error flag.

---
 rtl/mem_ctrl_pkg.sv | 40 ++++
 rtl/mem_wait_counter.sv | 32 +++
 rtl/mem_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_ctrl_pkg
// Brief   : Shared encodings and request-check helper for mem_access_ctrl.
// Revision: 1.0
// ============================================================================
package mem_ctrl_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    REQ_FETCH   = 2'b00,
    REQ_LOAD    = 2'b01,
    REQ_STORE   = 2'b10,
    REQ_ILLEGAL = 2'b11
  } req_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Stores into the low instruction words are refused so code cannot be overwritten.
  function automatic logic req_reject(
    input req_type_e         typ,
    input logic [WORD_W-1:0] addr,
    input logic [WORD_W-1:0] limit,
    input logic [WORD_W-1:0] inst_words
  );
    logic bad;
    bad = (addr[1:0] != 2'b00)
       || (addr >= limit)
       || (typ == REQ_ILLEGAL)
       || ((typ == REQ_STORE) && ({2'b00, addr[WORD_W-1:2]} < inst_words));
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// ============================================================================
// Module  : mem_wait_counter
// Brief   : 4-bit loadable down-counter that times memory wait states.
// Revision: 1.0
// ============================================================================
module mem_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_en,
  output logic       o_zero
);

  logic [3:0] r_count;

  // Saturates at zero so a long enable never wraps around.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_zero = (r_count == 4'd0);

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_ctrl
// Brief   : Sequences fetch/load/store transactions to the unified memory.
// Revision: 1.0
// ============================================================================
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_LIMIT  = 1024,
  parameter int INST_WORDS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_type,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [WORD_W-1:0] inst_reg,
  output logic [WORD_W-1:0] mem_data_reg,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam logic [3:0]        c_wait_ld    = 4'(WAIT_CYCLES);
  localparam logic [WORD_W-1:0] c_addr_limit = WORD_W'(ADDR_LIMIT);
  localparam logic [WORD_W-1:0] c_inst_words = WORD_W'(INST_WORDS);

  state_e            r_state;
  state_e            w_next;
  req_type_e         r_type;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_err;
  logic [WORD_W-1:0] r_inst;
  logic [WORD_W-1:0] r_mdr;

  logic              w_accept;
  logic              w_err;
  logic              w_wait_zero;
  logic              w_last;

  assign w_accept = (r_state == ST_IDLE) && req_valid;
  assign w_err    = req_reject(req_type_e'(req_type), req_addr, c_addr_limit, c_inst_words);
  assign w_last   = (r_state == ST_ACCESS) && w_wait_zero;

  mem_wait_counter u_wait (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_load_val (c_wait_ld),
    .i_en       (r_state == ST_ACCESS),
    .o_zero     (w_wait_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = w_err ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_addr = r_addr;
        if ((r_type == REQ_FETCH) || (r_type == REQ_LOAD)) begin
          mem_read = 1'b1;
        end
        // Write only on the final wait cycle so each store commits exactly once.
        if (r_type == REQ_STORE) begin
          mem_wdata = r_wdata;
          mem_write = w_wait_zero;
        end
        if (w_wait_zero) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        if (!r_err) begin
          if (r_type == REQ_FETCH) begin
            rsp_data = r_inst;
          end else if (r_type == REQ_LOAD) begin
            rsp_data = r_mdr;
          end
        end
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_type  <= REQ_FETCH;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_inst  <= '0;
      r_mdr   <= '0;
    end else begin
      if (w_accept) begin
        r_type  <= req_type_e'(req_type);
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_err   <= w_err;
      end
      if (w_last) begin
        if (r_type == REQ_FETCH) begin
          r_inst <= mem_rdata;
        end else if (r_type == REQ_LOAD) begin
          r_mdr <= mem_rdata;
        end
      end
    end
  end

  assign inst_reg     = r_inst;
  assign mem_data_reg = r_mdr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_ctrl
// Brief   : Self-checking bench; two controllers (0 and 2 wait states) with models.
// Revision: 1.0
// ============================================================================
module tb_mem_access_ctrl;

  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n        [N];
  logic        req_valid    [N];
  logic [1:0]  req_type     [N];
  logic [31:0] req_addr     [N];
  logic [31:0] req_wdata    [N];
  logic        req_ready    [N];
  logic        rsp_valid    [N];
  logic        rsp_err      [N];
  logic [31:0] rsp_data     [N];
  logic [31:0] inst_reg     [N];
  logic [31:0] mem_data_reg [N];
  logic [31:0] mem_addr     [N];
  logic [31:0] mem_wdata    [N];
  logic        mem_read     [N];
  logic        mem_write    [N];
  logic [31:0] mem_rdata    [N];

  logic [31:0] mem     [N][256];
  logic [31:0] ref_mem [N][256];
  logic [31:0] exp_inst [N];
  logic [31:0] exp_mdr  [N];
  int          wr_count [N];
  logic        do_init;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_access_ctrl #(
      .WAIT_CYCLES (2 * g),
      .ADDR_LIMIT  (1024),
      .INST_WORDS  (32)
    ) u_dut (
      .clk          (clk),
      .reset        (rst_n[g]),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_type     (req_type[g]),
      .req_addr     (req_addr[g]),
      .req_wdata    (req_wdata[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_data     (rsp_data[g]),
      .rsp_err      (rsp_err[g]),
      .inst_reg     (inst_reg[g]),
      .mem_data_reg (mem_data_reg[g]),
      .mem_addr     (mem_addr[g]),
      .mem_wdata    (mem_wdata[g]),
      .mem_read     (mem_read[g]),
      .mem_write    (mem_write[g]),
      .mem_rdata    (mem_rdata[g])
    );
    assign mem_rdata[g] = mem[g][mem_addr[g][9:2]];
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (do_init) begin
        for (int w = 0; w < 256; w++) mem[k][w] <= ref_mem[k][w];
        wr_count[k] <= 0;
      end else if (mem_write[k] === 1'b1) begin
        mem[k][mem_addr[k][9:2]] <= mem_wdata[k];
        wr_count[k] <= wr_count[k] + 1;
      end
    end
  end

  function automatic int wait_of(input int d);
    return 2 * d;
  endfunction

  function automatic bit model_err(input logic [1:0] t, input logic [31:0] a);
    return (a % 4 != 0) || (a >= 1024) || (t == 2'd3) || (t == 2'd2 && a / 4 < 32);
  endfunction

  // Drives one request, keeps garbage on req_* while busy, observes until response.
  task automatic run_req(input int d, input logic [1:0] t, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] data,
                         output logic err, output int nrd, output int nwr,
                         output logic [31:0] waddr, output logic [31:0] wdat,
                         output bit ready_ok);
    lat = 0; data = '0; err = 1'b0; nrd = 0; nwr = 0; waddr = '0; wdat = '0;
    ready_ok = (req_ready[d] === 1'b1);
    req_valid[d] = 1'b1; req_type[d] = t; req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk); #1;
    req_type[d] = 2'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom;
    for (int c = 1; c <= 40; c++) begin
      if (mem_read[d] === 1'b1) nrd++;
      if (mem_write[d] === 1'b1) begin nwr++; waddr = mem_addr[d]; wdat = mem_wdata[d]; end
      if (req_ready[d] !== 1'b0) ready_ok = 0;
      if (rsp_valid[d] === 1'b1) begin lat = c; data = rsp_data[d]; err = rsp_err[d]; break; end
      @(posedge clk); #1;
    end
    req_valid[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_type[k] = 2'd0;
      req_addr[k] = '0; req_wdata[k] = '0;
      for (int w = 0; w < 256; w++) ref_mem[k][w] = $urandom;
      ref_mem[k][0] = 32'h2004_0005;
    end
    do_init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({req_ready[k], rsp_valid[k], rsp_err[k], mem_read[k], mem_write[k]} !== 5'b10000) begin
        errors++;
        $display("FAIL reset_ctl[%0d]: got %b want 10000", k,
                 {req_ready[k], rsp_valid[k], rsp_err[k], mem_read[k], mem_write[k]});
      end
      checks++;
      if ({rsp_data[k], inst_reg[k], mem_data_reg[k], mem_addr[k], mem_wdata[k]} !== 160'd0) begin
        errors++;
        $display("FAIL reset_data[%0d]: got %h %h %h %h %h want all zero", k, rsp_data[k],
                 inst_reg[k], mem_data_reg[k], mem_addr[k], mem_wdata[k]);
      end
      exp_inst[k] = '0; exp_mdr[k] = '0;
    end
    for (int k = 0; k < N; k++) rst_n[k] = 1'b1;
    do_init = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch(input int d);
    int lat, nrd, nwr; logic [31:0] data, wa, wdt; logic err; bit rok;
    run_req(d, 2'd0, 32'h0, 32'h0, lat, data, err, nrd, nwr, wa, wdt, rok);
    exp_inst[d] = ref_mem[d][0];
    checks++; if (lat != wait_of(d) + 2) begin errors++; $display("FAIL fetch_lat: got %0d want %0d", lat, wait_of(d) + 2); end
    checks++; if (data !== 32'h2004_0005 || err !== 1'b0) begin errors++; $display("FAIL fetch_rsp: got %h err %b want 20040005 err 0", data, err); end
    checks++; if (inst_reg[d] !== 32'h2004_0005) begin errors++; $display("FAIL fetch_ir: got %h want 20040005", inst_reg[d]); end
    checks++; if (nwr != 0 || nrd != wait_of(d) + 1) begin errors++; $display("FAIL fetch_mem: got rd %0d wr %0d want rd %0d wr 0", nrd, nwr, wait_of(d) + 1); end
  endtask

  task automatic test_store_load(input int d);
    int lat, nrd, nwr, w0; logic [31:0] data, wa, wdt; logic err; bit rok;
    w0 = wr_count[d];
    run_req(d, 2'd2, 32'h80, 32'hDEAD_BEEF, lat, data, err, nrd, nwr, wa, wdt, rok);
    ref_mem[d][32] = 32'hDEAD_BEEF;
    checks++; if (nwr != 1 || wa !== 32'h80 || wdt !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_pulse: got %0d pulses addr %h data %h want 1 80 deadbeef", nwr, wa, wdt); end
    checks++; if (wr_count[d] - w0 != 1) begin errors++; $display("FAIL store_count: got %0d want 1", wr_count[d] - w0); end
    checks++; if (lat != wait_of(d) + 2 || data !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL store_rsp: got lat %0d data %h err %b want %0d 0 0", lat, data, err, wait_of(d) + 2); end
    run_req(d, 2'd1, 32'h80, 32'h0, lat, data, err, nrd, nwr, wa, wdt, rok);
    exp_mdr[d] = 32'hDEAD_BEEF;
    checks++; if (mem_data_reg[d] !== 32'hDEAD_BEEF || data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_mdr: got reg %h rsp %h want deadbeef", mem_data_reg[d], data); end
    checks++; if (inst_reg[d] !== exp_inst[d]) begin errors++; $display("FAIL load_ir_hold: got %h want %h", inst_reg[d], exp_inst[d]); end
  endtask

  task automatic test_errors(input int d);
    logic [1:0]  ty [4] = '{2'd2, 2'd1, 2'd0, 2'd3};
    logic [31:0] ad [4] = '{32'h10, 32'h82, 32'h400, 32'h100};
    int lat, nrd, nwr, w0; logic [31:0] data, wa, wdt; logic err; bit rok;
    for (int i = 0; i < 4; i++) begin
      w0 = wr_count[d];
      run_req(d, ty[i], ad[i], 32'hCAFE_F00D, lat, data, err, nrd, nwr, wa, wdt, rok);
      checks++; if (err !== 1'b1 || data !== 32'h0 || lat != 1) begin errors++; $display("FAIL err_rsp[%0d]: got err %b data %h lat %0d want 1 0 1", i, err, data, lat); end
      checks++; if (nrd != 0 || nwr != 0 || wr_count[d] != w0) begin errors++; $display("FAIL err_mem[%0d]: got rd %0d wr %0d want 0 0", i, nrd, nwr); end
      checks++; if (inst_reg[d] !== exp_inst[d] || mem_data_reg[d] !== exp_mdr[d]) begin errors++; $display("FAIL err_hold[%0d]: got %h %h want %h %h", i, inst_reg[d], mem_data_reg[d], exp_inst[d], exp_mdr[d]); end
    end
    checks++; if (mem[d][4] !== ref_mem[d][4]) begin errors++; $display("FAIL err_word10: got %h want %h", mem[d][4], ref_mem[d][4]); end
  endtask

  task automatic test_wait(input int d);
    int lat, nrd, nwr; logic [31:0] data, wa, wdt; logic err; bit rok;
    run_req(d, 2'd1, 32'h84, 32'h0, lat, data, err, nrd, nwr, wa, wdt, rok);
    exp_mdr[d] = ref_mem[d][33];
    checks++; if (nrd != wait_of(d) + 1 || lat != wait_of(d) + 2) begin errors++; $display("FAIL wait_timing: got rd %0d lat %0d want %0d %0d", nrd, lat, wait_of(d) + 1, wait_of(d) + 2); end
    checks++; if (!rok) begin errors++; $display("FAIL wait_ready: got ready high while busy want low"); end
    checks++; if (data !== ref_mem[d][33] || mem_data_reg[d] !== ref_mem[d][33]) begin errors++; $display("FAIL wait_data: got %h %h want %h", data, mem_data_reg[d], ref_mem[d][33]); end
  endtask

  task automatic test_back_to_back(input int d);
    int first, second, accepts; logic [31:0] d1, d2;
    first = -1; second = -1; d1 = '0; d2 = '0;
    accepts = (req_ready[d] === 1'b1) ? 1 : 0;
    req_valid[d] = 1'b1; req_type[d] = 2'd0; req_addr[d] = 32'h0;
    for (int c = 0; c < 60 && second < 0; c++) begin
      @(posedge clk); #1;
      if (rsp_valid[d] === 1'b1) begin
        if (first < 0) begin first = c; d1 = rsp_data[d]; req_addr[d] = 32'h4; end
        else begin second = c; d2 = rsp_data[d]; req_valid[d] = 1'b0; end
      end else if (req_ready[d] === 1'b1 && req_valid[d] === 1'b1) begin
        accepts++;
      end
    end
    req_valid[d] = 1'b0;
    @(posedge clk); #1;
    exp_inst[d] = ref_mem[d][1];
    checks++; if (first < 0 || second < 0 || second - first != wait_of(d) + 3) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", second - first, wait_of(d) + 3); end
    checks++; if (d1 !== ref_mem[d][0] || d2 !== ref_mem[d][1]) begin errors++; $display("FAIL b2b_data: got %h %h want %h %h", d1, d2, ref_mem[d][0], ref_mem[d][1]); end
    checks++; if (accepts != 2 || inst_reg[d] !== ref_mem[d][1]) begin errors++; $display("FAIL b2b_accept: got %0d accepts ir %h want 2 %h", accepts, inst_reg[d], ref_mem[d][1]); end
  endtask

  task automatic test_random(input int d, input int n);
    int lat, nrd, nwr, r, bad; logic [31:0] data, wa, wdt, a, wd, xd; logic err, xe; bit rok;
    logic [1:0] t;
    for (int i = 0; i < n; i++) begin
      t = 2'($urandom_range(0, 3)); r = $urandom_range(0, 9); wd = $urandom;
      if (r < 7)       a = 32'($urandom_range(0, 255)) * 4;
      else if (r == 7) a = 32'($urandom_range(0, 1023)) | 32'd1;
      else if (r == 8) a = 32'($urandom_range(256, 4000)) * 4;
      else             a = $urandom;
      xe = model_err(t, a);
      xd = (!xe && t < 2) ? ref_mem[d][a / 4] : 32'h0;
      run_req(d, t, a, wd, lat, data, err, nrd, nwr, wa, wdt, rok);
      if (!xe && t == 2'd0) exp_inst[d] = xd;
      if (!xe && t == 2'd1) exp_mdr[d] = xd;
      if (!xe && t == 2'd2) ref_mem[d][a / 4] = wd;
      checks++; if (err !== xe || data !== xd) begin errors++; $display("FAIL rnd_rsp[%0d] t%0d a%h: got err %b data %h want %b %h", i, t, a, err, data, xe, xd); end
      checks++; if (lat != (xe ? 1 : wait_of(d) + 2) || !rok) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d ready_ok %0d want %0d", i, lat, rok, xe ? 1 : wait_of(d) + 2); end
      checks++; if (nrd != ((!xe && t < 2) ? wait_of(d) + 1 : 0) || nwr != ((!xe && t == 2) ? 1 : 0)) begin errors++; $display("FAIL rnd_mem[%0d]: got rd %0d wr %0d", i, nrd, nwr); end
      checks++; if (inst_reg[d] !== exp_inst[d] || mem_data_reg[d] !== exp_mdr[d]) begin errors++; $display("FAIL rnd_regs[%0d]: got %h %h want %h %h", i, inst_reg[d], mem_data_reg[d], exp_inst[d], exp_mdr[d]); end
    end
    bad = 0;
    for (int w = 0; w < 256; w++) if (mem[d][w] !== ref_mem[d][w]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rnd_memory[%0d]: got %0d differing words want 0", d, bad); end
  endtask

  task automatic test_abort(input int d);
    int w0;
    w0 = wr_count[d];
    req_valid[d] = 1'b1; req_type[d] = 2'd2; req_addr[d] = 32'h88; req_wdata[d] = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    checks++; if (mem_write[d] !== 1'b0) begin errors++; $display("FAIL abort_early_write: got %b want 0", mem_write[d]); end
    rst_n[d] = 1'b0;
    @(posedge clk); #1;
    checks++; if ({req_ready[d], rsp_valid[d], rsp_err[d], mem_read[d], mem_write[d]} !== 5'b10000 ||
                  {rsp_data[d], inst_reg[d], mem_data_reg[d], mem_addr[d], mem_wdata[d]} !== 160'd0) begin
      errors++; $display("FAIL abort_outputs: got ready %b valid %b ir %h mdr %h addr %h want reset values",
                         req_ready[d], rsp_valid[d], inst_reg[d], mem_data_reg[d], mem_addr[d]);
    end
    rst_n[d] = 1'b1; exp_inst[d] = '0; exp_mdr[d] = '0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (req_ready[d] !== 1'b1 || wr_count[d] != w0) begin errors++; $display("FAIL abort_after: got ready %b writes %0d want 1 0", req_ready[d], wr_count[d] - w0); end
    checks++; if (mem[d][34] !== ref_mem[d][34]) begin errors++; $display("FAIL abort_word: got %h want %h", mem[d][34], ref_mem[d][34]); end
  endtask

  initial begin
    test_reset();
    test_fetch(0);
    test_store_load(0);
    test_store_load(1);
    test_errors(0);
    test_errors(1);
    test_wait(1);
    test_back_to_back(0);
    test_back_to_back(1);
    test_random(0, 40);
    test_random(1, 40);
    test_abort(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
